// File: rtl/spi_pkg.sv
// Shared SPI transfer types and constants.
// State encoding, direction codes and bit counts used by spi_xfer_ctrl.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW
  } state_t;

  localparam logic       SPI_DIR_READ  = 1'b1;
  localparam logic       SPI_DIR_WRITE = 1'b0;
  localparam logic [5:0] SPI_RD_BITS   = 6'd8;
  localparam logic [5:0] SPI_WR_BITS   = 6'd32;

  function automatic logic [5:0] xfer_bits(input logic dir);
    return (dir == SPI_DIR_READ) ? SPI_RD_BITS : SPI_WR_BITS;
  endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Request/response bundle between a host and spi_xfer_ctrl.
// cs_hold exists only when SPI_CS_HOLD_EN is defined.
interface spi_xfer_ctrl_if;

  logic        start;
  logic        dir;
  logic [31:0] tx_data;
`ifdef SPI_CS_HOLD_EN
  logic        cs_hold;
`endif
  logic        busy;
  logic        done;
  logic [7:0]  rx_data;

  modport master (
`ifdef SPI_CS_HOLD_EN
    output cs_hold,
`endif
    output start, dir, tx_data,
    input  busy, done, rx_data
  );

  modport slave (
`ifdef SPI_CS_HOLD_EN
    input  cs_hold,
`endif
    input  start, dir, tx_data,
    output busy, done, rx_data
  );

endinterface

// File: rtl/spi_clk_div.sv
// Phase timer: loadable down-counter, tick on the last
// cycle of every CLK_DIV-cycle phase.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign tick = (cnt == 8'd0);

  // Reload at transfer start and at each phase end.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (load || tick) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master: 32-bit writes, 8-bit reads.
// Optional SPI_CS_HOLD_EN keeps cs_n low across transfers.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            reset,
  spi_xfer_ctrl_if.slave  bus,
  output logic            sclk,
  output logic            mosi,
  input  logic            miso,
  output logic            cs_n
);

  state_t      state;
  logic        dir_q;
  logic [31:0] tx_q;
  logic [7:0]  sh;
  logic [5:0]  bit_cnt;
  logic        tick;
  logic        load;
`ifdef SPI_CS_HOLD_EN
  logic        hold_q;
`endif

  assign load = (state == IDLE) && bus.start;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .tick  (tick)
  );

  // Transfer sequencer with registered SPI pins and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.rx_data <= 8'd0;
      cs_n        <= 1'b1;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      dir_q       <= 1'b0;
      tx_q        <= 32'd0;
      sh          <= 8'd0;
      bit_cnt     <= 6'd0;
`ifdef SPI_CS_HOLD_EN
      hold_q      <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= SETUP;
            bus.busy <= 1'b1;
            cs_n     <= 1'b0;
            sclk     <= 1'b0;
            dir_q    <= bus.dir;
            tx_q     <= {bus.tx_data[30:0], 1'b0};
            bit_cnt  <= 6'd0;
            if (bus.dir == SPI_DIR_READ) begin
              mosi <= 1'b1;
            end else begin
              mosi <= bus.tx_data[31];
            end
`ifdef SPI_CS_HOLD_EN
            hold_q   <= bus.cs_hold;
`endif
          end
        end
        SETUP: begin
          if (tick) begin
            state <= HIGH;
            sclk  <= 1'b1;
            sh    <= {sh[6:0], miso};
          end
        end
        HIGH: begin
          if (tick) begin
            state   <= LOW;
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt + 6'd1;
            if (dir_q == SPI_DIR_WRITE) begin
              mosi <= tx_q[31];
              tx_q <= {tx_q[30:0], 1'b0};
            end
          end
        end
        LOW: begin
          if (tick) begin
            if (bit_cnt == xfer_bits(dir_q)) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              mosi     <= 1'b0;
`ifdef SPI_CS_HOLD_EN
              cs_n     <= ~hold_q;
`else
              cs_n     <= 1'b1;
`endif
              if (dir_q == SPI_DIR_READ) begin
                bus.rx_data <= sh;
              end
            end else begin
              state <= HIGH;
              sclk  <= 1'b1;
              sh    <= {sh[6:0], miso};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: CLK_DIV=4 and CLK_DIV=1 instances.
// Define SPI_CS_HOLD_EN to also exercise chip-select hold.
module tb_spi_xfer_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_xfer_ctrl_if i4();
  spi_xfer_ctrl_if i1();

  logic sclk4, mosi4, cs4;
  logic miso4 = 1'b0;
  logic sclk1, mosi1, cs1;
  logic miso1 = 1'b0;

  spi_xfer_ctrl #(.CLK_DIV(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (i4.slave),
    .sclk  (sclk4),
    .mosi  (mosi4),
    .miso  (miso4),
    .cs_n  (cs4)
  );

  spi_xfer_ctrl #(.CLK_DIV(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (i1.slave),
    .sclk  (sclk1),
    .mosi  (mosi1),
    .miso  (miso1),
    .cs_n  (cs1)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] last_rx4 = 8'h00;

  function automatic int exp_busy(input int div, input logic d);
    return (1 + 2 * (d ? 8 : 32)) * div;
  endfunction

  task automatic drive(input bit sel, input logic st,
                       input logic d, input logic [31:0] tx);
    if (sel) begin
      i1.start = st; i1.dir = d; i1.tx_data = tx;
    end else begin
      i4.start = st; i4.dir = d; i4.tx_data = tx;
    end
  endtask

  task automatic set_miso(input bit sel, input logic v);
    if (sel) miso1 = v;
    else miso4 = v;
  endtask

  task automatic run_xfer(
    input  bit sel, input logic d, input logic [31:0] tx,
    input  logic [7:0] sb, input int poke_a, input int poke_b,
    output int busy_cyc, output int dones, output int rises,
    output int toggles, output int csn_pre,
    output logic [31:0] mw, output logic all1,
    output logic [7:0] rx_done);
    int idx;
    int after;
    bit seen;
    logic ps, b, dn, s, m, cn;
    idx = 0; after = 0; seen = 0; ps = 1'b0;
    busy_cyc = 0; dones = 0; rises = 0; toggles = 0;
    csn_pre = 0; mw = 32'd0; all1 = 1'b1; rx_done = 8'd0;
    @(negedge clk);
    drive(sel, 1'b1, d, tx);
    set_miso(sel, sb[7]);
    for (int c = 0; c < 700 && after < 5; c++) begin
      @(negedge clk);
      drive(sel, (c == poke_a || c == poke_b), d, tx);
      b  = sel ? i1.busy : i4.busy;
      dn = sel ? i1.done : i4.done;
      s  = sel ? sclk1 : sclk4;
      m  = sel ? mosi1 : mosi4;
      cn = sel ? cs1 : cs4;
      if (seen) after++;
      if (b) busy_cyc++;
      if (dn) begin
        dones++;
        seen = 1;
        rx_done = sel ? i1.rx_data : i4.rx_data;
      end
      if (!seen && cn) csn_pre++;
      if (s != ps) toggles++;
      if (s && !ps) begin
        rises++;
        mw = {mw[30:0], m};
      end
      if (b && m !== 1'b1) all1 = 1'b0;
      if (ps && !s) idx++;
      set_miso(sel, (idx < 8) ? sb[7 - idx] : 1'b0);
      ps = s;
    end
  endtask

  task automatic test_reset();
    logic [12:0] got;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    got = {i4.busy, i4.done, cs4, sclk4, mosi4, i4.rx_data};
    checks++;
    if (got !== 13'b0_0_1_0_0_00000000) begin
      errors++;
      $display("FAIL reset4 got %b exp 0010000000000", got);
    end
    got = {i1.busy, i1.done, cs1, sclk1, mosi1, i1.rx_data};
    checks++;
    if (got !== 13'b0_0_1_0_0_00000000) begin
      errors++;
      $display("FAIL reset1 got %b exp 0010000000000", got);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    got = {i4.busy, i4.done, cs4, sclk4, mosi4, i4.rx_data};
    checks++;
    if (got !== 13'b0_0_1_0_0_00000000) begin
      errors++;
      $display("FAIL idle4 got %b exp 0010000000000", got);
    end
  endtask

  task automatic check_xfer(
    input string nm, input int div, input logic d,
    input logic [31:0] tx, input logic [7:0] exp_rx,
    input int busy_cyc, input int dones, input int rises,
    input int csn_pre, input logic [31:0] mw, input logic all1,
    input logic [7:0] rx_done);
    checks++;
    if (busy_cyc != exp_busy(div, d)) begin
      errors++;
      $display("FAIL %s_busy got %0d exp %0d",
               nm, busy_cyc, exp_busy(div, d));
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL %s_done got %0d exp 1", nm, dones);
    end
    checks++;
    if (rises != (d ? 8 : 32)) begin
      errors++;
      $display("FAIL %s_rises got %0d exp %0d",
               nm, rises, d ? 8 : 32);
    end
    checks++;
    if (csn_pre != 0) begin
      errors++;
      $display("FAIL %s_csn got %0d exp 0", nm, csn_pre);
    end
    checks++;
    if (d ? (all1 !== 1'b1) : (mw !== tx)) begin
      errors++;
      $display("FAIL %s_mosi got %h/%b exp %h/1",
               nm, mw, all1, tx);
    end
    checks++;
    if (rx_done !== exp_rx) begin
      errors++;
      $display("FAIL %s_rx got %h exp %h", nm, rx_done, exp_rx);
    end
  endtask

  task automatic test_write();
    int bc, dn, rs, tg, cp;
    logic [31:0] mw;
    logic a1;
    logic [7:0] rx;
    run_xfer(0, 1'b0, 32'hA5C3_0F81, 8'h00, -1, -1,
             bc, dn, rs, tg, cp, mw, a1, rx);
    check_xfer("write", 4, 1'b0, 32'hA5C3_0F81, last_rx4,
               bc, dn, rs, cp, mw, a1, rx);
  endtask

  task automatic test_read();
    int bc, dn, rs, tg, cp;
    logic [31:0] mw;
    logic a1;
    logic [7:0] rx;
    run_xfer(0, 1'b1, 32'h0, 8'h6B, -1, -1,
             bc, dn, rs, tg, cp, mw, a1, rx);
    check_xfer("read", 4, 1'b1, 32'h0, 8'h6B,
               bc, dn, rs, cp, mw, a1, rx);
    last_rx4 = 8'h6B;
  endtask

  task automatic test_ignore_start();
    int bc, dn, rs, tg, cp;
    logic [31:0] mw;
    logic a1;
    logic [7:0] rx;
    run_xfer(0, 1'b0, 32'h1234_5678, 8'h00, 10, 50,
             bc, dn, rs, tg, cp, mw, a1, rx);
    check_xfer("ignore", 4, 1'b0, 32'h1234_5678, last_rx4,
               bc, dn, rs, cp, mw, a1, rx);
  endtask

  task automatic test_back_to_back();
    bit seen;
    int bc;
    logic [3:0] got;
    seen = 0;
    miso4 = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h0);
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      drive(0, 1'b0, 1'b1, 32'h0);
      if (i4.done) begin
        seen = 1;
        drive(0, 1'b1, 1'b1, 32'h0);
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_first_done got 0 exp 1");
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h0);
    got = {i4.busy, cs4, sclk4, mosi4};
    checks++;
    if (got !== 4'b1001) begin
      errors++;
      $display("FAIL b2b_setup got %b exp 1001", got);
    end
    bc = 1;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (i4.busy) bc++;
      if (i4.done) seen = 1;
    end
    checks++;
    if (bc != exp_busy(4, 1'b1)) begin
      errors++;
      $display("FAIL b2b_busy got %0d exp %0d",
               bc, exp_busy(4, 1'b1));
    end
    checks++;
    if (i4.rx_data !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_rx got %h exp ff", i4.rx_data);
    end
    last_rx4 = 8'hFF;
  endtask

  task automatic test_reset_abort();
    int rs, dn;
    logic ps;
    logic [2:0] got;
    rs = 0; dn = 0; ps = 1'b0;
    miso4 = 1'b1;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h0);
    for (int c = 0; c < 200 && rs < 5; c++) begin
      @(negedge clk);
      drive(0, 1'b0, 1'b1, 32'h0);
      if (sclk4 && !ps) rs++;
      if (i4.done) dn++;
      ps = sclk4;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    got = {i4.busy, cs4, sclk4};
    checks++;
    if (got !== 3'b010) begin
      errors++;
      $display("FAIL abort_state got %b exp 010", got);
    end
    repeat (80) begin
      @(negedge clk);
      if (i4.done) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL abort_done got %0d exp 0", dn);
    end
    checks++;
    if (i4.rx_data !== 8'h00) begin
      errors++;
      $display("FAIL abort_rx got %h exp 00", i4.rx_data);
    end
    last_rx4 = 8'h00;
  endtask

  task automatic test_clkdiv1();
    int bc, dn, rs, tg, cp;
    logic [31:0] mw;
    logic a1;
    logic [7:0] rx;
    logic [7:0] sb;
    run_xfer(1, 1'b1, 32'h0, 8'h80, -1, -1,
             bc, dn, rs, tg, cp, mw, a1, rx);
    check_xfer("div1", 1, 1'b1, 32'h0, 8'h80,
               bc, dn, rs, cp, mw, a1, rx);
    checks++;
    if (tg != bc - 1) begin
      errors++;
      $display("FAIL div1_toggle got %0d exp %0d", tg, bc - 1);
    end
    sb = 8'($urandom);
    run_xfer(1, 1'b1, 32'h0, sb, -1, -1,
             bc, dn, rs, tg, cp, mw, a1, rx);
    check_xfer("div1_rand", 1, 1'b1, 32'h0, sb,
               bc, dn, rs, cp, mw, a1, rx);
  endtask

  task automatic test_random();
    int bc, dn, rs, tg, cp;
    logic [31:0] mw, tx;
    logic a1, d;
    logic [7:0] rx, sb, exp_rx;
    for (int n = 0; n < 8; n++) begin
      d  = 1'($urandom);
      tx = $urandom;
      sb = 8'($urandom);
      exp_rx = d ? sb : last_rx4;
      run_xfer(0, d, tx, sb, -1, -1,
               bc, dn, rs, tg, cp, mw, a1, rx);
      check_xfer("rand", 4, d, tx, exp_rx,
                 bc, dn, rs, cp, mw, a1, rx);
      last_rx4 = exp_rx;
    end
  endtask

`ifdef SPI_CS_HOLD_EN
  task automatic test_cs_hold();
    int bc, dn, rs, tg, cp;
    logic [31:0] mw;
    logic a1;
    logic [7:0] rx;
    i4.cs_hold = 1'b1;
    run_xfer(0, 1'b0, 32'hDEAD_BEEF, 8'h00, -1, -1,
             bc, dn, rs, tg, cp, mw, a1, rx);
    checks++;
    if (cs4 !== 1'b0) begin
      errors++;
      $display("FAIL hold_after_write got %b exp 0", cs4);
    end
    i4.cs_hold = 1'b0;
    run_xfer(0, 1'b1, 32'h0, 8'h5A, -1, -1,
             bc, dn, rs, tg, cp, mw, a1, rx);
    checks++;
    if (cp != 0) begin
      errors++;
      $display("FAIL hold_gap got %0d exp 0", cp);
    end
    checks++;
    if (cs4 !== 1'b1) begin
      errors++;
      $display("FAIL hold_release got %b exp 1", cs4);
    end
    last_rx4 = rx;
  endtask
`endif

  initial begin
    drive(0, 1'b0, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0);
`ifdef SPI_CS_HOLD_EN
    i4.cs_hold = 1'b0;
    i1.cs_hold = 1'b0;
`endif
    test_reset();
    test_write();
    test_read();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_clkdiv1();
    test_random();
`ifdef SPI_CS_HOLD_EN
    test_cs_hold();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter: CLK_DIV, default 4, SPI half-period in clk cycles (legal 1..255).
REQ-002 SHALL have port: clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  transfer request, sampled only when busy=0.
REQ-005 SHALL have port: dir  input  1  1 = read 8 bits, 0 = write 32 bits; sampled with start.
REQ-006 SHALL have port: tx_data  input  32  write word, sent MSB first; sampled with start.
REQ-007 SHALL have port: cs_hold  input  1  keep cs_n asserted after done; present only with SPI_CS_HOLD_EN.
REQ-008 SHALL have port: busy  output  1  transfer in progress.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: rx_data  output  8  last byte read, MSB first.
REQ-011 SHALL have port: sclk  output  1  SPI clock, mode 0 (idle low).
REQ-012 SHALL have port: mosi  output  1  serial data out.
REQ-013 SHALL have port: miso  input  1  serial data in.
REQ-014 SHALL have port: cs_n  output  1  active-low chip select.

Function
REQ-015 SHALL implement states IDLE, SETUP, HIGH, LOW; N = 8 when dir=1, 32 when dir=0.
REQ-016 SHALL, in IDLE with start=1, latch dir/tx_data and enter SETUP next cycle with busy=1, cs_n=0, sclk=0, mosi=bit 31 (write) or 1 (read).
REQ-017 SHALL stay CLK_DIV cycles in SETUP, then alternate HIGH (sclk=1) and LOW (sclk=0), CLK_DIV cycles each, N times.
REQ-018 SHALL sample miso on the cycle sclk rises (entry to HIGH), shifting it into an internal 8-bit register LSB-in.
REQ-019 SHALL update mosi to the next tx bit on entry to LOW (falling sclk); read transfers hold mosi=1 throughout.
REQ-020 SHALL, after the N-th LOW phase, return to IDLE: busy=0, cs_n=1, done=1 for exactly one cycle.
REQ-021 SHALL keep busy high for exactly (1+2N)*CLK_DIV cycles (write, CLK_DIV=4: 260; read: 68).
REQ-022 SHALL load rx_data from the shift register on the done cycle of read transfers only; writes leave rx_data unchanged.
REQ-023 SHALL ignore start while busy=1; start coincident with the done cycle is accepted (IDLE reached that cycle).
REQ-024 SHALL use a counter wide enough for CLK_DIV=255 and a 6-bit bit counter; CLK_DIV=1 gives sclk = clk/2.

Reset
REQ-025 SHALL, on reset=1 at any time, force IDLE, busy=0, done=0, cs_n=1, sclk=0, mosi=0, rx_data=0, counters=0.
REQ-026 SHALL abort a transfer on mid-operation reset without a done pulse and without updating rx_data.

Configuration
REQ-027 SHALL use macro SPI_CS_HOLD_EN: when defined, cs_hold is present and latched with start; when defined and latched cs_hold=1, cs_n stays 0 after done until a later transfer completes with cs_hold=0 or reset.
REQ-028 SHALL, without SPI_CS_HOLD_EN, omit cs_hold; cs_n always returns to 1 at done.

Structure
REQ-029 SHALL take from shared package spi_pkg: state enum, SPI_DIR_READ=1/SPI_DIR_WRITE=0, SPI_RD_BITS=8, SPI_WR_BITS=32.
REQ-030 SHALL instantiate one sub-module spi_clk_div: loadable down-counter emitting a one-cycle phase tick every CLK_DIV cycles.

Verification
REQ-031 SHALL verify write: dir=0, tx_data=0xA5C3_0F81, CLK_DIV=4 -> 32 rising sclk edges, mosi at each rise = A5C30F81 MSB first, busy 260 cycles, one done.
REQ-032 SHALL verify read: dir=1, slave drives 0x6B on miso -> mosi=1 throughout, 8 rising edges, rx_data=0x6B on done cycle, busy 68 cycles.
REQ-033 SHALL verify start pulsed at cycles 10 and 50 of a write -> ignored, exactly one done; start on done cycle -> new SETUP next cycle.
REQ-034 SHALL verify reset at bit 5 of a read -> cs_n=1, sclk=0, busy=0 next cycle, no done, rx_data unchanged.
REQ-035 SHALL verify CLK_DIV=1 read of 0x80 -> sclk toggles every cycle, busy 17 cycles, rx_data=0x80.
REQ-036 SHALL verify with SPI_CS_HOLD_EN: write cs_hold=1 then read cs_hold=0 -> cs_n low continuously between transfers, high after second done.
